// File: rtl/serv_fetch_ctrl.sv
// Instruction-fetch sequencer: runs ibus read cycles, hands words to the decoder,
// and optionally keeps a one-word PC+4 prefetch buffer.
module serv_fetch_ctrl #(
  parameter bit PREFETCH = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_fetch_req,
  input  logic [31:0]      i_fetch_adr,
  input  logic             i_flush,
  output logic [31:0]      o_ibus_adr,
  output logic             o_ibus_cyc,
  input  logic [31:0]      i_ibus_rdt,
  input  logic             i_ibus_ack,
  output logic [29:0]      o_dec_rdt,
  output logic             o_dec_en,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_hit_cnt
);

  // WAIT is the idle bus cycle between a discarded prefetch and the redirected demand.
  typedef enum logic [1:0] {IDLE, DEMAND, PREF, WAIT} state_t;

  state_t           state, state_d;
  logic [29:0]      adr, adr_d;
  logic [29:0]      tgt, tgt_d;
  logic             cyc, cyc_d;
  logic [29:0]      dec_rdt, dec_rdt_d;
  logic             dec_en, dec_en_d;
  logic             busy, busy_d;
  logic [CNT_W-1:0] hit_cnt, hit_cnt_d;
  logic             pbuf_valid, pbuf_valid_d;
  logic [29:0]      pbuf_adr, pbuf_adr_d;
  logic [29:0]      pbuf_dat, pbuf_dat_d;
  logic             pref_go, pref_go_d;
  logic             discard, discard_d;
  logic             promoted, promoted_d;

  logic        req;
  logic [29:0] req_adr;
  logic [CNT_W-1:0] hit_inc;
  logic        unused_bits;

  assign req         = i_fetch_req && !busy;
  assign req_adr     = i_fetch_adr[31:2];
  assign hit_inc     = (hit_cnt == '1) ? hit_cnt : hit_cnt + CNT_W'(1);
  assign unused_bits = ^{i_fetch_adr[1:0], i_ibus_rdt[1:0]};

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d      = state;
    adr_d        = adr;
    tgt_d        = tgt;
    cyc_d        = cyc;
    dec_rdt_d    = dec_rdt;
    dec_en_d     = 1'b0;
    busy_d       = busy;
    hit_cnt_d    = hit_cnt;
    pbuf_valid_d = pbuf_valid && !i_flush;
    pbuf_adr_d   = pbuf_adr;
    pbuf_dat_d   = pbuf_dat;
    pref_go_d    = pref_go;
    discard_d    = discard;
    promoted_d   = promoted;

    unique case (state)
      IDLE: begin
        if (req) begin
          pref_go_d = 1'b0;
          // A hit right behind a delivery would pulse o_dec_en twice in a row; refetch instead.
          if (PREFETCH && pbuf_valid && !i_flush && !dec_en && pbuf_adr == req_adr) begin
            dec_en_d     = 1'b1;
            dec_rdt_d    = pbuf_dat;
            pbuf_valid_d = 1'b0;
            hit_cnt_d    = hit_inc;
            pref_go_d    = 1'b1;
            tgt_d        = req_adr + 30'(1);
          end else begin
            state_d = DEMAND;
            cyc_d   = 1'b1;
            adr_d   = req_adr;
            busy_d  = 1'b1;
          end
        end else if (pref_go && !i_flush) begin
          state_d    = PREF;
          cyc_d      = 1'b1;
          adr_d      = tgt;
          pref_go_d  = 1'b0;
          discard_d  = 1'b0;
          promoted_d = 1'b0;
        end else if (i_flush) begin
          pref_go_d = 1'b0;
        end
      end

      DEMAND: begin
        if (i_ibus_ack) begin
          state_d    = IDLE;
          cyc_d      = 1'b0;
          busy_d     = 1'b0;
          dec_en_d   = 1'b1;
          dec_rdt_d  = i_ibus_rdt[31:2];
          pref_go_d  = PREFETCH;
          tgt_d      = adr + 30'(1);
          promoted_d = 1'b0;
          if (promoted) hit_cnt_d = hit_inc;
        end
      end

      PREF: begin
        if (i_ibus_ack) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          if (busy) begin
            state_d = WAIT;
          end else if (req && req_adr == adr && !discard && !i_flush) begin
            dec_en_d  = 1'b1;
            dec_rdt_d = i_ibus_rdt[31:2];
            hit_cnt_d = hit_inc;
            pref_go_d = 1'b1;
            tgt_d     = adr + 30'(1);
          end else if (req) begin
            state_d = WAIT;
            busy_d  = 1'b1;
            tgt_d   = req_adr;
          end else if (!discard && !i_flush) begin
            pbuf_valid_d = 1'b1;
            pbuf_adr_d   = adr;
            pbuf_dat_d   = i_ibus_rdt[31:2];
          end
        end else begin
          if (i_flush) discard_d = 1'b1;
          if (req) begin
            busy_d = 1'b1;
            if (req_adr == adr && !discard && !i_flush) begin
              state_d    = DEMAND;
              promoted_d = 1'b1;
            end else begin
              discard_d = 1'b1;
              tgt_d     = req_adr;
            end
          end
        end
      end

      WAIT: begin
        state_d   = DEMAND;
        cyc_d     = 1'b1;
        adr_d     = tgt;
        discard_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase

    if (!PREFETCH) pbuf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      adr        <= '0;
      tgt        <= '0;
      cyc        <= 1'b0;
      dec_rdt    <= '0;
      dec_en     <= 1'b0;
      busy       <= 1'b0;
      hit_cnt    <= '0;
      pbuf_valid <= 1'b0;
      pbuf_adr   <= '0;
      pbuf_dat   <= '0;
      pref_go    <= 1'b0;
      discard    <= 1'b0;
      promoted   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_d;
      adr        <= adr_d;
      tgt        <= tgt_d;
      cyc        <= cyc_d;
      dec_rdt    <= dec_rdt_d;
      dec_en     <= dec_en_d;
      busy       <= busy_d;
      hit_cnt    <= hit_cnt_d;
      pbuf_valid <= pbuf_valid_d;
      pbuf_adr   <= pbuf_adr_d;
      pbuf_dat   <= pbuf_dat_d;
      pref_go    <= pref_go_d;
      discard    <= discard_d;
      promoted   <= promoted_d;
    end
  end

  assign o_ibus_adr = {adr, 2'b00};
  assign o_ibus_cyc = cyc;
  assign o_dec_rdt  = dec_rdt;
  assign o_dec_en   = dec_en;
  assign o_busy     = busy;
  assign o_hit_cnt  = hit_cnt;

endmodule

// File: tb/tb_serv_fetch_ctrl.sv
// Directed bench for serv_fetch_ctrl: a prefetching instance and a demand-only instance.
module tb_serv_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req = 1'b0, flush = 1'b0, ack = 1'b0;
  logic [31:0] adr = '0, rdt = '0;
  logic [31:0] ibus_adr;
  logic        cyc, dec_en, busy;
  logic [29:0] dec_rdt;
  logic [7:0]  hit_cnt;

  logic        req0 = 1'b0, ack0 = 1'b0;
  logic [31:0] adr0 = '0, rdt0 = '0;
  logic [31:0] ibus_adr0;
  logic        cyc0, dec_en0, busy0;
  logic [29:0] dec_rdt0;
  logic [7:0]  hit_cnt0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serv_fetch_ctrl #(.PREFETCH(1'b1), .CNT_W(8)) dut (
    .clk(clk), .i_rst(rst), .i_fetch_req(req), .i_fetch_adr(adr), .i_flush(flush),
    .o_ibus_adr(ibus_adr), .o_ibus_cyc(cyc), .i_ibus_rdt(rdt), .i_ibus_ack(ack),
    .o_dec_rdt(dec_rdt), .o_dec_en(dec_en), .o_busy(busy), .o_hit_cnt(hit_cnt)
  );

  serv_fetch_ctrl #(.PREFETCH(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .i_rst(rst), .i_fetch_req(req0), .i_fetch_adr(adr0), .i_flush(1'b0),
    .o_ibus_adr(ibus_adr0), .o_ibus_cyc(cyc0), .i_ibus_rdt(rdt0), .i_ibus_ack(ack0),
    .o_dec_rdt(dec_rdt0), .o_dec_en(dec_en0), .o_busy(busy0), .o_hit_cnt(hit_cnt0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] a);
    req = 1'b1; adr = a; tick(); req = 1'b0;
  endtask

  task automatic bus_ack(input logic [31:0] d);
    ack = 1'b1; rdt = d; tick(); ack = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst cyc", 32'(cyc), 32'h0);
    check("rst adr", ibus_adr, 32'h0);
    check("rst dec_en", 32'(dec_en), 32'h0);
    check("rst dec_rdt", 32'(dec_rdt), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst hit", 32'(hit_cnt), 32'h0);

    // Cold miss
    request(32'h100);
    check("miss cyc", 32'(cyc), 32'h1);
    check("miss adr", ibus_adr, 32'h100);
    check("miss busy", 32'(busy), 32'h1);
    tick(); tick();
    check("miss cyc held", 32'(cyc), 32'h1);
    bus_ack(32'h0050_0093);
    check("miss dec_en", 32'(dec_en), 32'h1);
    check("miss dec_rdt", 32'(dec_rdt), 32'h0014_0024);
    check("miss cyc drop", 32'(cyc), 32'h0);
    check("miss busy drop", 32'(busy), 32'h0);
    tick();
    check("pref1 cyc", 32'(cyc), 32'h1);
    check("pref1 adr", ibus_adr, 32'h104);
    check("pref1 dec_en low", 32'(dec_en), 32'h0);

    // Sequential hit from the buffer
    bus_ack(32'h0010_8113);
    check("fill no dec_en", 32'(dec_en), 32'h0);
    check("fill cyc", 32'(cyc), 32'h0);
    request(32'h104);
    check("hit dec_en", 32'(dec_en), 32'h1);
    check("hit dec_rdt", 32'(dec_rdt), 32'h0004_2044);
    check("hit busy", 32'(busy), 32'h0);
    check("hit cnt", 32'(hit_cnt), 32'h1);
    tick();
    check("pref2 adr", ibus_adr, 32'h108);
    check("pref2 cyc", 32'(cyc), 32'h1);
    check("dec_rdt stable", 32'(dec_rdt), 32'h0004_2044);

    // Redirect during prefetch
    request(32'h200);
    check("redir busy", 32'(busy), 32'h1);
    check("redir cyc held", 32'(cyc), 32'h1);
    check("redir adr held", ibus_adr, 32'h108);
    bus_ack(32'hDEAD_BEEF);
    check("redir drop dec_en", 32'(dec_en), 32'h0);
    check("redir gap cyc", 32'(cyc), 32'h0);
    check("redir gap busy", 32'(busy), 32'h1);
    tick();
    check("redir demand adr", ibus_adr, 32'h200);
    check("redir demand cyc", 32'(cyc), 32'h1);
    bus_ack(32'h1234_5678);
    check("redir dec_en", 32'(dec_en), 32'h1);
    check("redir dec_rdt", 32'(dec_rdt), 32'h048D_159E);
    check("redir hit cnt", 32'(hit_cnt), 32'h1);
    tick();
    check("pref3 adr", ibus_adr, 32'h204);

    // Flush of a valid buffer, then flush of an in-flight prefetch
    bus_ack(32'h0);
    request(32'h108);
    check("miss108 adr", ibus_adr, 32'h108);
    bus_ack(32'h2222_2222);
    tick();
    check("pref10c adr", ibus_adr, 32'h10C);
    bus_ack(32'h1111_1111);
    flush = 1'b1; tick(); flush = 1'b0;
    request(32'h10C);
    check("flush miss cyc", 32'(cyc), 32'h1);
    check("flush miss adr", ibus_adr, 32'h10C);
    check("flush miss dec_en", 32'(dec_en), 32'h0);
    check("flush hit cnt", 32'(hit_cnt), 32'h1);
    bus_ack(32'h3333_3333);
    check("flush dec_rdt", 32'(dec_rdt), 32'h0CCC_CCCC);
    tick();
    check("pref110 adr", ibus_adr, 32'h110);
    flush = 1'b1; tick(); flush = 1'b0;
    bus_ack(32'h4444_4444);
    check("flushed pref no dec_en", 32'(dec_en), 32'h0);
    request(32'h110);
    check("flushed pref miss busy", 32'(busy), 32'h1);
    check("flushed pref miss dec_en", 32'(dec_en), 32'h0);
    bus_ack(32'h5555_5555);
    tick();

    // Promotion of the in-flight prefetch, then request coinciding with ack
    request(32'h114);
    check("promote busy", 32'(busy), 32'h1);
    check("promote adr", ibus_adr, 32'h114);
    bus_ack(32'h6666_6664);
    check("promote dec_en", 32'(dec_en), 32'h1);
    check("promote dec_rdt", 32'(dec_rdt), 32'h1999_9999);
    check("promote hit cnt", 32'(hit_cnt), 32'h2);
    check("promote busy drop", 32'(busy), 32'h0);
    tick();
    check("pref118 adr", ibus_adr, 32'h118);
    req = 1'b1; adr = 32'h118; ack = 1'b1; rdt = 32'h7777_777C;
    tick();
    req = 1'b0; ack = 1'b0;
    check("coincide dec_en", 32'(dec_en), 32'h1);
    check("coincide dec_rdt", 32'(dec_rdt), 32'h1DDD_DDDF);
    check("coincide hit cnt", 32'(hit_cnt), 32'h3);
    tick();

    // Address wrap, then reset in the middle of a prefetch
    bus_ack(32'h0);
    request(32'hFFFF_FFFC);
    check("wrap demand adr", ibus_adr, 32'hFFFF_FFFC);
    bus_ack(32'h0000_0013);
    tick();
    check("wrap pref adr", ibus_adr, 32'h0);
    check("wrap pref cyc", 32'(cyc), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid rst cyc", 32'(cyc), 32'h0);
    check("mid rst adr", ibus_adr, 32'h0);
    check("mid rst dec_rdt", 32'(dec_rdt), 32'h0);
    check("mid rst hit", 32'(hit_cnt), 32'h0);
    check("mid rst busy", 32'(busy), 32'h0);
    bus_ack(32'hFFFF_FFFF);
    check("late ack dec_en", 32'(dec_en), 32'h0);
    check("late ack cyc", 32'(cyc), 32'h0);
    check("late ack dec_rdt", 32'(dec_rdt), 32'h0);

    // Demand-only build
    req0 = 1'b1; adr0 = 32'h0; tick(); req0 = 1'b0;
    check("np dem0 cyc", 32'(cyc0), 32'h1);
    check("np dem0 busy", 32'(busy0), 32'h1);
    ack0 = 1'b1; rdt0 = 32'h0000_0093; tick(); ack0 = 1'b0;
    check("np dem0 dec_en", 32'(dec_en0), 32'h1);
    check("np dem0 dec_rdt", 32'(dec_rdt0), 32'h0000_0024);
    tick(); tick();
    check("np no pref", 32'(cyc0), 32'h0);
    req0 = 1'b1; adr0 = 32'h4; tick(); req0 = 1'b0;
    check("np dem4 cyc", 32'(cyc0), 32'h1);
    check("np dem4 adr", ibus_adr0, 32'h4);
    ack0 = 1'b1; rdt0 = 32'h0000_0113; tick(); ack0 = 1'b0;
    check("np dem4 dec_en", 32'(dec_en0), 32'h1);
    tick(); tick();
    check("np no pref 2", 32'(cyc0), 32'h0);
    check("np hit cnt", 32'(hit_cnt0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serv_fetch_ctrl.md
Name: serv_fetch_ctrl

Overview:
Instruction-fetch sequencer between the core's ibus request and the instruction decoder. It runs Wishbone-style ibus read cycles and delivers each fetched word to the decoder as a one-cycle enable with the instruction bits. An optional one-word prefetch buffer speculatively fetches PC+4 so that sequential fetches complete in one cycle. It handles redirects and flushes so that stale words never reach the decoder.

Parameters:
PREFETCH, 1, 1 = enable the one-word PC+4 prefetch buffer; 0 = demand fetch only
CNT_W, 8, width of the saturating prefetch-hit counter

Ports:
clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_fetch_req  input  1  one-cycle pulse: fetch the instruction at i_fetch_adr; ignored while o_busy=1
i_fetch_adr  input  32  fetch address; bits [1:0] ignored
i_flush  input  1  one-cycle pulse: invalidate the prefetch buffer and any in-flight prefetch
o_ibus_adr  output  32  ibus address, bits [1:0] always 0
o_ibus_cyc  output  1  ibus cycle request, held until i_ibus_ack
i_ibus_rdt  input  32  ibus read data, valid with ack
i_ibus_ack  input  1  ibus acknowledge, single cycle
o_dec_rdt  output  30  instruction bits [31:2] to the decoder
o_dec_en  output  1  one-cycle pulse: o_dec_rdt holds a new instruction
o_busy  output  1  demand fetch outstanding
o_hit_cnt  output  CNT_W  count of prefetch hits, saturating at all-ones

Behaviour:
- Reset values: o_ibus_cyc=0, o_ibus_adr=0, o_dec_en=0, o_dec_rdt=0, o_busy=0, o_hit_cnt=0; state=IDLE; buffer invalid; discard flag clear.
- Reset mid-cycle: o_ibus_cyc drops on the reset edge. Any later ack is ignored while in IDLE.
- States:
  - IDLE
  - DEMAND: bus cycle for a requested word
  - PREF: speculative bus cycle for last_adr+4
- Buffer: pbuf_valid, pbuf_adr[31:2], pbuf_dat[31:2]. It exists only when PREFETCH=1; with PREFETCH=0, PREF is never entered.
- Hit: a request in IDLE with pbuf_valid and pbuf_adr==i_fetch_adr[31:2].
  - Next cycle: o_dec_rdt=pbuf_dat, o_dec_en=1, pbuf_valid=0, o_hit_cnt increments.
  - The cycle after that: enter PREF at adr+4. o_busy never rises on a hit.
- Miss in IDLE:
  - Next cycle: state=DEMAND, o_ibus_cyc=1, o_ibus_adr={adr[31:2],2'b00}, o_busy=1.
  - Ack at cycle M: at M+1, o_dec_rdt=i_ibus_rdt[31:2], o_dec_en=1, o_ibus_cyc=0, o_busy=0.
  - At M+2: PREF at adr+4 if PREFETCH=1, otherwise IDLE.
- Request during PREF:
  - Address matches the prefetch address: promote to demand by setting o_busy=1. On ack, deliver as in DEMAND (counts as a hit). The ack-to-o_dec_en latency is 1 cycle, and a request coinciding with the ack also delivers at the next cycle.
  - Address mismatch: set the discard flag and latch the requested address with o_busy=1. o_ibus_cyc stays asserted until ack, because a cycle is never aborted. Ack data is dropped, then DEMAND starts at the latched address after one idle bus cycle.
- PREF ack with no request: fill the buffer (pbuf_valid=1), go to IDLE, no o_dec_en.
- i_flush:
  - Clears pbuf_valid. In PREF, sets discard, so the ack does not fill the buffer.
  - In DEMAND it has no effect; the demanded word is still delivered.
  - Flush and request in the same cycle: the flush applies first and the request is treated as a miss.
- Request while o_busy=1: protocol violation; ignored with no state change.
- Bus spacing: o_ibus_cyc is low for at least one cycle between consecutive bus cycles.
- Address arithmetic: PC+4 is computed on bits [31:2] modulo 2^30, so 0xFFFFFFFC wraps to 0x00000000.
- o_dec_en is never high on two consecutive cycles.
- o_dec_rdt is stable between pulses.
- o_hit_cnt holds at 2^CNT_W-1 once reached.

Test Plan:
- Cold miss: reset, request 0x100, ack after 3 cycles with 0x00500093 -> o_ibus_adr=0x100; o_dec_en one cycle after ack, o_dec_rdt=0x00500093>>2; then PREF at 0x104.
- Sequential hit: after scenario 1, PREF ack with 0x00108113, then request 0x104 -> o_dec_en next cycle with data>>2; o_busy stays 0; o_hit_cnt=1; PREF at 0x108 starts.
- Redirect during PREF: while PREF at 0x108 is pending, request 0x200 -> o_ibus_cyc held until ack, that data is never delivered; then DEMAND at 0x200 delivers its own word.
- Flush: a buffer is valid at 0x10C; i_flush, then request 0x10C -> miss; DEMAND issued at 0x10C; o_hit_cnt unchanged.
- Wrap and reset: demand 0xFFFFFFFC -> PREF address 0x00000000; assert i_rst mid-PREF -> next cycle o_ibus_cyc=0, all outputs at reset values, late ack ignored.
- PREFETCH=0 build: two sequential requests 0x0 and 0x4 -> two DEMAND cycles, no PREF ever, o_hit_cnt=0.
